// File: rtl/intersection_ctrl_if.sv
// Signal bundle between the intersection scheduler and whatever drives requests
// and consumes lamp/display outputs.
interface intersection_ctrl_if;
   logic            en;
   logic            ns_ped_req;
   logic            ew_ped_req;
   logic            ns_green;
   logic            ns_yellow;
   logic            ns_red;
   logic            ew_green;
   logic            ew_yellow;
   logic            ew_red;
   logic            ns_walk;
   logic            ew_walk;
   logic            ns_ped_pend;
   logic            ew_ped_pend;
   logic [1:0][7:0] display_led;

   modport master (
      output en, ns_ped_req, ew_ped_req,
      input  ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red,
      input  ns_walk, ew_walk, ns_ped_pend, ew_ped_pend, display_led
   );

   modport slave (
      input  en, ns_ped_req, ew_ped_req,
      output ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red,
      output ns_walk, ew_walk, ns_ped_pend, ew_ped_pend, display_led
   );
endinterface

// File: rtl/intersection_ctrl.sv
// Two-head intersection scheduler: all-red separated NS/EW phases driven by a
// seconds countdown, with pedestrian requests shortening the opposing green.
//
// state     | meaning
// ALLRED_A  | clearance before NS green, both heads red
// NS_GREEN  | NS green + walk, EW red
// NS_YELLOW | NS yellow, EW red
// ALLRED_B  | clearance before EW green, both heads red
// EW_GREEN  | EW green + walk, NS red
// EW_YELLOW | EW yellow, NS red
module intersection_ctrl #(
   parameter int pSECOND_CNT_VALUE = 99,
   parameter int pGREEN_INIT_VAL   = 14,
   parameter int pYELLOW_INIT_VAL  = 2,
   parameter int pALLRED_INIT_VAL  = 1,
   parameter int pPED_CUT_VAL      = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   intersection_ctrl_if.slave  bus
);

   localparam int PW = (pSECOND_CNT_VALUE < 1) ? 1 : $clog2(pSECOND_CNT_VALUE + 1);

   typedef enum logic [2:0] {
      ALLRED_A, NS_GREEN, NS_YELLOW, ALLRED_B, EW_GREEN, EW_YELLOW
   } state_t;

   state_t        state_q, state_d;
   logic [6:0]    count_q, count_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          ns_pend_q, ns_pend_d;
   logic          ew_pend_q, ew_pend_d;
   logic          tick;
   logic          cut;

   function automatic state_t next_of(input state_t s);
      case (s)
         ALLRED_A:  next_of = NS_GREEN;
         NS_GREEN:  next_of = NS_YELLOW;
         NS_YELLOW: next_of = ALLRED_B;
         ALLRED_B:  next_of = EW_GREEN;
         EW_GREEN:  next_of = EW_YELLOW;
         default:   next_of = ALLRED_A;
      endcase
   endfunction

   function automatic logic [6:0] init_of(input state_t s);
      case (s)
         NS_GREEN, EW_GREEN:   init_of = 7'(pGREEN_INIT_VAL);
         NS_YELLOW, EW_YELLOW: init_of = 7'(pYELLOW_INIT_VAL);
         default:              init_of = 7'(pALLRED_INIT_VAL);
      endcase
   endfunction

   assign tick = bus.en && (presc_q == PW'(pSECOND_CNT_VALUE));
   // Truncation is not gated by en: a pending crossing shortens green even while frozen.
   assign cut  = (count_q > 7'(pPED_CUT_VAL)) &&
                 (((state_q == NS_GREEN) && ew_pend_q) ||
                  ((state_q == EW_GREEN) && ns_pend_q));

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      presc_d   = presc_q;
      ns_pend_d = ns_pend_q;
      ew_pend_d = ew_pend_q;

      if (bus.en) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end

      if (cut) begin
         count_d = 7'(pPED_CUT_VAL);
      end else if (tick) begin
         if (count_q != 7'd0) begin
            count_d = count_q - 7'd1;
         end else begin
            state_d = next_of(state_q);
            count_d = init_of(state_d);
         end
      end

      if (bus.ns_ped_req && (state_q != NS_GREEN)) ns_pend_d = 1'b1;
      if (bus.ew_ped_req && (state_q != EW_GREEN)) ew_pend_d = 1'b1;
      // Entering a green serves that direction's crossing; clear wins over a same-cycle set.
      if ((state_d == NS_GREEN) && (state_q != NS_GREEN)) ns_pend_d = 1'b0;
      if ((state_d == EW_GREEN) && (state_q != EW_GREEN)) ew_pend_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ALLRED_A;
         count_q   <= 7'(pALLRED_INIT_VAL);
         presc_q   <= '0;
         ns_pend_q <= 1'b0;
         ew_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         presc_q   <= presc_d;
         ns_pend_q <= ns_pend_d;
         ew_pend_q <= ew_pend_d;
      end
   end

   always_comb begin
      bus.ns_green  = 1'b0;
      bus.ns_yellow = 1'b0;
      bus.ns_red    = 1'b0;
      bus.ew_green  = 1'b0;
      bus.ew_yellow = 1'b0;
      bus.ew_red    = 1'b0;
      case (state_q)
         NS_GREEN:  begin bus.ns_green  = 1'b1; bus.ew_red = 1'b1; end
         NS_YELLOW: begin bus.ns_yellow = 1'b1; bus.ew_red = 1'b1; end
         EW_GREEN:  begin bus.ew_green  = 1'b1; bus.ns_red = 1'b1; end
         EW_YELLOW: begin bus.ew_yellow = 1'b1; bus.ns_red = 1'b1; end
         default:   begin bus.ns_red    = 1'b1; bus.ew_red = 1'b1; end
      endcase
   end

   assign bus.ns_walk        = (state_q == NS_GREEN);
   assign bus.ew_walk        = (state_q == EW_GREEN);
   assign bus.ns_ped_pend    = ns_pend_q;
   assign bus.ew_ped_pend    = ew_pend_q;
   assign bus.display_led[1] = 8'(count_q / 7'd10);
   assign bus.display_led[0] = 8'(count_q % 7'd10);

endmodule
